// File: rtl/sys_bus_pkg.sv
// Shared definitions for the sys_bus responder and its lane helper.
// Holds the read/write control encodings, the NOP instruction returned
// for out-of-range fetches, the responder FSM state type and two helpers
// that map a control code to its access size (log2 of the byte count).
package sys_bus_pkg;

  localparam logic [2:0] RD_NONE = 3'b000;
  localparam logic [2:0] RD_LB   = 3'b001;
  localparam logic [2:0] RD_LBU  = 3'b010;
  localparam logic [2:0] RD_LH   = 3'b011;
  localparam logic [2:0] RD_LHU  = 3'b100;
  localparam logic [2:0] RD_LW   = 3'b101;
  localparam logic [2:0] RD_LWU  = 3'b110;
  localparam logic [2:0] RD_LD   = 3'b111;

  localparam logic [2:0] WR_NONE = 3'b000;
  localparam logic [2:0] WR_SB   = 3'b001;
  localparam logic [2:0] WR_SH   = 3'b010;
  localparam logic [2:0] WR_SW   = 3'b011;
  localparam logic [2:0] WR_SD   = 3'b100;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Access size as log2(bytes): 0 byte, 1 half, 2 word, 3 double
  function automatic logic [1:0] rd_size(input logic [2:0] rd);
    case (rd)
      RD_LB, RD_LBU: return 2'd0;
      RD_LH, RD_LHU: return 2'd1;
      RD_LW, RD_LWU: return 2'd2;
      default:       return 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] wr_size(input logic [2:0] wr);
    case (wr)
      WR_SB:   return 2'd0;
      WR_SH:   return 2'd1;
      WR_SW:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/sys_bus_lane.sv
// Combinational byte-lane helper for a 64-bit memory word.
// Extracts and sign/zero-extends the addressed lane for reads, merges
// right-aligned store data into the word for writes, and flags accesses
// that are not naturally aligned.
// Ports:
//   rd_ctrl, wr_ctrl : access type (read type takes priority for sizing)
//   offset           : byte offset within the word
//   word             : current memory word
//   din              : right-aligned store data
//   rd_data          : extended load result
//   wr_word          : word with the addressed bytes replaced
//   misaligned       : access crosses its natural alignment
module sys_bus_lane
  import sys_bus_pkg::*;
(
  input  logic [2:0]  rd_ctrl,
  input  logic [2:0]  wr_ctrl,
  input  logic [2:0]  offset,
  input  logic [63:0] word,
  input  logic [63:0] din,
  output logic [63:0] rd_data,
  output logic [63:0] wr_word,
  output logic        misaligned
);

  logic [1:0]  size;
  logic [63:0] shifted;
  logic [63:0] din_shifted;
  logic [7:0]  base_mask;
  logic [7:0]  byte_mask;

  // Size and alignment: a size-2^n access needs the low n offset bits clear
  always_comb begin
    size = (rd_ctrl != RD_NONE) ? rd_size(rd_ctrl) : wr_size(wr_ctrl);
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = offset[0];
      2'd2:    misaligned = |offset[1:0];
      default: misaligned = |offset;
    endcase
  end

  // Read path: bring the addressed lane down to bit 0, then extend
  always_comb begin
    shifted = word >> {offset, 3'b000};
    rd_data = '0;
    case (rd_ctrl)
      RD_LB:   rd_data = {{56{shifted[7]}}, shifted[7:0]};
      RD_LBU:  rd_data = {56'b0, shifted[7:0]};
      RD_LH:   rd_data = {{48{shifted[15]}}, shifted[15:0]};
      RD_LHU:  rd_data = {48'b0, shifted[15:0]};
      RD_LW:   rd_data = {{32{shifted[31]}}, shifted[31:0]};
      RD_LWU:  rd_data = {32'b0, shifted[31:0]};
      RD_LD:   rd_data = shifted;
      default: rd_data = '0;
    endcase
  end

  // Write path: move store data up to the lane and replace only masked bytes
  always_comb begin
    case (size)
      2'd0:    base_mask = 8'h01;
      2'd1:    base_mask = 8'h03;
      2'd2:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
    byte_mask   = base_mask << offset;
    din_shifted = din << {offset, 3'b000};
    wr_word     = word;
    for (int i = 0; i < 8; i++) begin
      if (byte_mask[i]) wr_word[8*i +: 8] = din_shifted[8*i +: 8];
    end
  end

endmodule

// File: rtl/sys_bus_mem_responder.sv
// Responder end of sys_bus: a word-organised RAM with a fixed access
// latency. Data requests are latched in IDLE, wait WAIT_CYCLES cycles,
// access the RAM on the edge entering RESP and pulse bus_ready for one
// cycle. With no data request pending, IDLE serves 32-bit instruction
// fetches every cycle.
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-low reset
//   bus_rd_ctrl  : load type, 0 = none
//   bus_wr_ctrl  : store type, 0 = none, 5..7 reserved
//   bus_addr     : byte address
//   bus_din      : right-aligned store data
//   bus_dout     : load data or fetched instruction
//   bus_ready    : one-cycle completion pulse for data accesses
//   bus_err      : access faulted, valid with bus_ready
module sys_bus_mem_responder
  import sys_bus_pkg::*;
#(
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  bus_rd_ctrl,
  input  logic [2:0]  bus_wr_ctrl,
  input  logic [63:0] bus_addr,
  input  logic [63:0] bus_din,
  output logic [63:0] bus_dout,
  output logic        bus_ready,
  output logic        bus_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [63:0] mem [DEPTH];

  state_t      state;
  logic [3:0]  cnt;
  logic [2:0]  req_rd;
  logic [2:0]  req_wr;
  logic [63:0] req_addr;
  logic [63:0] req_din;

  logic [2:0]    eff_rd;
  logic [2:0]    eff_wr;
  logic [63:0]   eff_addr;
  logic [63:0]   eff_din;
  logic [AW-1:0] word_idx;
  logic [63:0]   mem_word;
  logic [63:0]   rd_data;
  logic [63:0]   wr_word;
  logic [63:0]   resp_dout;
  logic [31:0]   fetch_half;
  logic          misaligned;
  logic          out_of_range;
  logic          both_ctrl;
  logic          wr_reserved;
  logic          fault;
  logic          req_present;
  logic          enter_resp;
  logic          do_write;

  // In IDLE the live bus drives the single RAM port (fetches, and the
  // zero-wait access that completes on the accepting edge); elsewhere the
  // latched request does, so input changes during WAIT have no effect.
  always_comb begin
    eff_rd   = req_rd;
    eff_wr   = req_wr;
    eff_addr = req_addr;
    eff_din  = req_din;
    if (state == ST_IDLE) begin
      eff_rd   = bus_rd_ctrl;
      eff_wr   = bus_wr_ctrl;
      eff_addr = bus_addr;
      eff_din  = bus_din;
    end
  end

  assign word_idx     = eff_addr[3 +: AW];
  assign mem_word     = mem[word_idx];
  assign out_of_range = |eff_addr[63:3+AW];
  assign both_ctrl    = (eff_rd != RD_NONE) && (eff_wr != WR_NONE);
  assign wr_reserved  = eff_wr > WR_SD;
  assign fault        = misaligned | out_of_range | both_ctrl | wr_reserved;
  assign fetch_half   = eff_addr[2] ? mem_word[63:32] : mem_word[31:0];
  assign resp_dout    = (fault || eff_rd == RD_NONE) ? 64'b0 : rd_data;

  assign req_present = (bus_rd_ctrl != RD_NONE) || (bus_wr_ctrl != WR_NONE);
  assign enter_resp  = ((state == ST_IDLE) && req_present && (WAIT_CYCLES == 0)) ||
                       ((state == ST_WAIT) && (cnt == 4'd0));
  assign do_write    = rst && enter_resp && !fault && (eff_wr != WR_NONE);

  sys_bus_lane u_lane (
    .rd_ctrl    (eff_rd),
    .wr_ctrl    (eff_wr),
    .offset     (eff_addr[2:0]),
    .word       (mem_word),
    .din        (eff_din),
    .rd_data    (rd_data),
    .wr_word    (wr_word),
    .misaligned (misaligned)
  );

  // RAM write port: read-modify-write of the whole word on the edge
  // entering RESP; gated by rst so a reset mid-access discards the store.
  always_ff @(posedge clk) begin
    if (do_write) mem[word_idx] <= wr_word;
  end

  // Control FSM with request latches, wait counter and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      req_rd    <= RD_NONE;
      req_wr    <= WR_NONE;
      req_addr  <= '0;
      req_din   <= '0;
      bus_dout  <= '0;
      bus_ready <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      bus_ready <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_present) begin
            req_rd   <= bus_rd_ctrl;
            req_wr   <= bus_wr_ctrl;
            req_addr <= bus_addr;
            req_din  <= bus_din;
            if (WAIT_CYCLES == 0) begin
              state     <= ST_RESP;
              bus_ready <= 1'b1;
              bus_err   <= fault;
              bus_dout  <= resp_dout;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end else begin
            bus_dout <= out_of_range ? {32'b0, NOP_INSN} : {32'b0, fetch_half};
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= ST_RESP;
            bus_ready <= 1'b1;
            bus_err   <= fault;
            bus_dout  <= resp_dout;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_bus_mem_responder.sv
// Self-checking bench for sys_bus_mem_responder: one instance with two
// wait states and one with none, sharing clock and reset.
module tb_sys_bus_mem_responder;
  import sys_bus_pkg::*;

  localparam int DEPTH = 4096;
  localparam int WAITS = 2;

  logic        clk;
  logic        rst;

  logic [2:0]  s_rd, s_wr;
  logic [63:0] s_addr, s_din, s_dout;
  logic        s_ready, s_err;

  logic [2:0]  f_rd, f_wr;
  logic [63:0] f_addr, f_din, f_dout;
  logic        f_ready, f_err;

  typedef struct {
    logic [63:0] dout;
    bit          chk;
    bit          err;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;
  logic [63:0] vals [10];

  sys_bus_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_rd_ctrl (s_rd),
    .bus_wr_ctrl (s_wr),
    .bus_addr    (s_addr),
    .bus_din     (s_din),
    .bus_dout    (s_dout),
    .bus_ready   (s_ready),
    .bus_err     (s_err)
  );

  sys_bus_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .bus_rd_ctrl (f_rd),
    .bus_wr_ctrl (f_wr),
    .bus_addr    (f_addr),
    .bus_din     (f_din),
    .bus_dout    (f_dout),
    .bus_ready   (f_ready),
    .bus_err     (f_err)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic driveReq(input bit fast, input logic [2:0] rd, input logic [2:0] wr,
                          input logic [63:0] addr, input logic [63:0] din);
    if (fast) begin
      f_rd = rd; f_wr = wr; f_addr = addr; f_din = din;
    end else begin
      s_rd = rd; s_wr = wr; s_addr = addr; s_din = din;
    end
  endtask

  // Counts rising edges until bus_ready is seen at a falling edge (bounded)
  task automatic waitReady(input bit fast, input string tag, output int lat);
    logic rdy;
    lat = 0;
    rdy = 1'b0;
    while (!rdy && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      rdy = fast ? f_ready : s_ready;
    end
    if (!rdy) checkOutput({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic popCompare(input bit fast, input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb_q.pop_front();
    if (e.chk) checkOutput({tag, "_dout"}, fast ? f_dout : s_dout, e.dout);
    checkOutput({tag, "_err"}, {63'b0, fast ? f_err : s_err}, {63'b0, e.err});
  endtask

  // One complete access from IDLE; called at a falling edge, returns at
  // the falling edge of the IDLE cycle after the response.
  task automatic applyStimulus(input bit fast, input string tag,
                               input logic [2:0] rd, input logic [2:0] wr,
                               input logic [63:0] addr, input logic [63:0] din,
                               input logic [63:0] exp_dout, input bit chk, input bit exp_err);
    int lat;
    driveReq(fast, rd, wr, addr, din);
    sb_q.push_back('{exp_dout, chk, exp_err});
    waitReady(fast, tag, lat);
    checkOutput({tag, "_lat"}, 64'(lat), fast ? 64'd1 : 64'(WAITS + 1));
    popCompare(fast, tag);
    driveReq(fast, RD_NONE, WR_NONE, 64'd0, 64'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, {63'b0, fast ? f_ready : s_ready}, 64'd0);
  endtask

  task automatic fetchCheck(input string tag, input logic [63:0] addr, input logic [63:0] exp);
    driveReq(1'b0, RD_NONE, WR_NONE, addr, 64'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput(tag, s_dout, exp);
  endtask

  initial begin
    int lat;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    driveReq(1'b0, RD_NONE, WR_NONE, 64'd0, 64'd0);
    driveReq(1'b1, RD_NONE, WR_NONE, 64'd0, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_dout",   s_dout, 64'd0);
    checkOutput("rst_ready",  {63'b0, s_ready}, 64'd0);
    checkOutput("rst_err",    {63'b0, s_err}, 64'd0);
    checkOutput("rst_dout0",  f_dout, 64'd0);
    checkOutput("rst_ready0", {63'b0, f_ready}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] basic loads on two-wait-state instance");
    applyStimulus(0, "preload_sd", RD_NONE, WR_SD, 64'd0, 64'h8877_6655_4433_2211, 64'd0, 0, 0);
    applyStimulus(0, "lb7",  RD_LB,  WR_NONE, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FF88, 1, 0);
    applyStimulus(0, "lbu7", RD_LBU, WR_NONE, 64'd7, 64'd0, 64'h0000_0000_0000_0088, 1, 0);
    applyStimulus(0, "lw4",  RD_LW,  WR_NONE, 64'd4, 64'd0, 64'hFFFF_FFFF_8877_6655, 1, 0);
    applyStimulus(0, "lhu6", RD_LHU, WR_NONE, 64'd6, 64'd0, 64'h0000_0000_0000_8877, 1, 0);

    $display("[TB] idle fetch");
    fetchCheck("fetch_4",   64'd4, 64'h0000_0000_8877_6655);
    fetchCheck("fetch_0",   64'd0, 64'h0000_0000_4433_2211);
    fetchCheck("fetch_7",   64'd7, 64'h0000_0000_8877_6655);
    fetchCheck("fetch_oor", 64'(DEPTH * 8), 64'h0000_0000_0000_0013);
    driveReq(1'b0, RD_NONE, WR_NONE, 64'd0, 64'd0);

    $display("[TB] faults");
    applyStimulus(0, "lw6_mis",  RD_LW,   WR_NONE, 64'd6, 64'd0, 64'd0, 1, 1);
    applyStimulus(0, "sd4_mis",  RD_NONE, WR_SD,   64'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 1);
    applyStimulus(0, "both",     RD_LD,   WR_SD,   64'd0, 64'h1111_1111_1111_1111, 64'd0, 1, 1);
    applyStimulus(0, "resv_wr",  RD_NONE, 3'b101,  64'd0, 64'h2222_2222_2222_2222, 64'd0, 1, 1);
    applyStimulus(0, "ld_oor",   RD_LD,   WR_NONE, 64'(DEPTH * 8), 64'd0, 64'd0, 1, 1);
    applyStimulus(0, "ld0_kept", RD_LD,   WR_NONE, 64'd0, 64'd0, 64'h8877_6655_4433_2211, 1, 0);

    $display("[TB] reset during wait");
    driveReq(1'b0, RD_NONE, WR_SW, 64'd0, 64'h0000_0000_DEAD_BEEF);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("rstmid_ready", {63'b0, s_ready}, 64'd0);
    end
    checkOutput("rstmid_dout", s_dout, 64'd0);
    driveReq(1'b0, RD_NONE, WR_NONE, 64'd0, 64'd0);
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("rstmid_idle", {63'b0, s_ready}, 64'd0);
    end
    applyStimulus(0, "lw0_old", RD_LW, WR_NONE, 64'd0, 64'd0, 64'h0000_0000_4433_2211, 1, 0);

    $display("[TB] writes");
    applyStimulus(0, "sh2",    RD_NONE, WR_SH, 64'd2, 64'h0000_0000_0000_ABCD, 64'd0, 0, 0);
    applyStimulus(0, "ld0_sh", RD_LD,   WR_NONE, 64'd0, 64'd0, 64'h8877_6655_ABCD_2211, 1, 0);
    applyStimulus(0, "sd8",    RD_NONE, WR_SD, 64'd8, 64'h0123_4567_89AB_CDEF, 64'd0, 0, 0);
    applyStimulus(0, "ld8",    RD_LD,   WR_NONE, 64'd8, 64'd0, 64'h0123_4567_89AB_CDEF, 1, 0);
    applyStimulus(0, "sb13",   RD_NONE, WR_SB, 64'd13, 64'h0000_0000_0000_0F5A, 64'd0, 0, 0);
    applyStimulus(0, "ld8_sb", RD_LD,   WR_NONE, 64'd8, 64'd0, 64'h0123_5A67_89AB_CDEF, 1, 0);

    $display("[TB] request held past ready");
    driveReq(1'b0, RD_LBU, WR_NONE, 64'd7, 64'd0);
    sb_q.push_back('{64'h88, 1'b1, 1'b0});
    sb_q.push_back('{64'h88, 1'b1, 1'b0});
    waitReady(0, "hold1", lat);
    checkOutput("hold1_lat", 64'(lat), 64'(WAITS + 1));
    popCompare(0, "hold1");
    waitReady(0, "hold2", lat);
    checkOutput("hold2_lat", 64'(lat), 64'(WAITS + 2));
    popCompare(0, "hold2");
    driveReq(1'b0, RD_NONE, WR_NONE, 64'd0, 64'd0);
    @(posedge clk);
    @(negedge clk);

    $display("[TB] zero-wait instance");
    for (int i = 0; i < 10; i++) begin
      vals[i] = {$urandom, $urandom};
      applyStimulus(1, "w0_sd", RD_NONE, WR_SD, 64'(i * 8), vals[i], 64'd0, 0, 0);
    end
    for (int i = 0; i < 10; i++) begin
      driveReq(1'b1, RD_LD, WR_NONE, 64'(i * 8), 64'd0);
      sb_q.push_back('{vals[i], 1'b1, 1'b0});
      waitReady(1, "b2b", lat);
      checkOutput("b2b_period", 64'(lat), (i == 0) ? 64'd1 : 64'd2);
      popCompare(1, "b2b");
    end
    driveReq(1'b1, RD_NONE, WR_NONE, 64'd0, 64'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b_end_pulse", {63'b0, f_ready}, 64'd0);

    checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
